button_event_ctrl: RTL and testbench
====================================

// Module: button_event_ctrl
// PURPOSE
//  Debounce controller for the board push-buttons. Samples N synchronised buttons only on the
//  slow tick from clock_enable, runs a per-button debounce/long-press FSM, arbitrates the
//  resulting events and queues them in a small FIFO drained by the Avalon/CPU side with valid/ready.
// PARAMETERS
//  N_BTN         4   number of buttons (1..8)
//  STABLE_TICKS  3   consecutive ticks at the new level needed to commit a press/release (>=1)
//  HOLD_TICKS    100 ticks held after commit before one LONG event is issued (>=1)
//  FIFO_DEPTH    4   event FIFO entries (power of two, >=2)
// PORTS
//  clk        in   1               system clock
//  reset      in   1               synchronous, active-high reset
//  tick_en    in   1               1-cycle slow enable (clock_enable.slow_clk_en)
//  btn_raw    in   N_BTN           asynchronous button levels, 1 = pressed
//  btn_state  out  N_BTN           debounced level per button
//  evt_valid  out  1               FIFO head valid
//  evt_ready  in   1               consumer pops head when evt_valid & evt_ready
//  evt_type   out  2               head type: 01 PRESS, 10 RELEASE, 11 LONG
//  evt_idx    out  3               head button index
//  overflow   out  1               sticky: an event was dropped; cleared only by reset
// BEHAVIOUR
//  - Reset: btn_state=0, evt_valid=0, evt_type=0, evt_idx=0, overflow=0; all FSMs RELEASED,
//    counters 0, pending slots empty, FIFO empty, sync flops 0. Reset mid-operation discards all.
//  - btn_raw passes a 2-flop synchroniser (s); FSMs advance only in cycles with tick_en=1.
//  - Per-button FSM (cnt = debounce counter, hcnt = hold counter, long_done flag):
//    RELEASED:  s=1 -> if STABLE_TICKS==1 commit PRESS else PRESS_PEND, cnt=1.
//    PRESS_PEND: s=1 -> cnt+1; when cnt+1==STABLE_TICKS -> PRESSED, emit PRESS, hcnt=0,
//               long_done=0. s=0 -> RELEASED, cnt=0 (glitch rejected, no event).
//    PRESSED:   s=0 -> RELEASE_PEND, cnt=1 (or commit RELEASE if STABLE_TICKS==1).
//               s=1 -> if !long_done: hcnt+1; at hcnt+1==HOLD_TICKS emit LONG, long_done=1.
//    RELEASE_PEND: s=0 -> cnt+1; at STABLE_TICKS -> RELEASED, emit RELEASE.
//               s=1 -> PRESSED, cnt=0; hcnt and long_done kept (no second LONG).
//  - btn_state = 1 in PRESSED and RELEASE_PEND; updates in the cycle after the committing tick.
//  - Emit writes a per-button pending slot {type}. Slot already full -> event dropped, overflow=1.
//  - Arbiter: each cycle the lowest-index full slot is pushed into FIFO if FIFO count<DEPTH
//    (count as registered at cycle start; a same-cycle pop does not free space). Slot clears on push.
//    A slot emitted and pushed in the same cycle is not possible: push uses the registered slot.
//  - FIFO: show-ahead; evt_type/evt_idx reflect head whenever evt_valid=1, hold values otherwise.
//    Pop and push may occur in the same cycle; count unchanged. Pointers wrap at FIFO_DEPTH.
//  - Latency: raw edge to first sampled tick = 2 cycles sync; committed event visible on
//    evt_valid 2 cycles after the committing tick (slot register, FIFO write) if FIFO empty.
//  - tick_en while reset=1 is ignored.
// STRUCTURE
//  - Package btn_evt_pkg: evt_type_t enum (EVT_NONE=0,PRESS=1,RELEASE=2,LONG=3), btn_fsm_t
//    enum (RELEASED,PRESS_PEND,PRESSED,RELEASE_PEND), event struct {evt_type_t t; logic[2:0] idx}.
//  - Sub-module btn_evt_fifo (parameterised depth, valid/ready pop, push/full) instantiated once;
//    FSMs, synchroniser and arbiter inline via generate loop.
// TESTING  (STABLE_TICKS=3, HOLD_TICKS=5, FIFO_DEPTH=4, N_BTN=4, tick_en every 4th cycle)
//  - Clean press of btn0 held 3 ticks -> one PRESS idx0, btn_state[0]=1; release 3 ticks ->
//    RELEASE idx0, btn_state[0]=0.
//  - btn1 high for 2 ticks then low -> no event, btn_state[1] stays 0, overflow=0.
//  - btn2 held 8 ticks after commit -> exactly one LONG idx2 after 5 ticks; bounce in
//    release (1 tick low, then high) -> no RELEASE, no second LONG.
//  - btn0..3 commit PRESS on the same tick -> FIFO holds idx0,1,2,3 in order over 4 cycles.
//  - evt_ready=0, generate 6 events across buttons -> FIFO full at 4, pending slots stall,
//    a 2nd event on a stalled button sets overflow=1; drain -> remaining events in index order.
//  - Assert reset while FIFO non-empty and btn held -> next cycle evt_valid=0, btn_state=0,
//    overflow=0; held button re-debounced after release of reset.

Source files
------------

// File: rtl/btn_evt_pkg.sv
// Shared types for the push-button event controller: event codes, debounce FSM states
// and the queued event record.
package btn_evt_pkg;

  typedef enum logic [1:0] {
    EVT_NONE = 2'd0,
    PRESS    = 2'd1,
    RELEASE  = 2'd2,
    LONG     = 2'd3
  } evt_type_t;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } btn_fsm_t;

  typedef struct packed {
    evt_type_t  t;
    logic [2:0] idx;
  } btn_evt_t;

  // The debounced level stays high while a release is still being confirmed.
  function automatic logic is_held(input btn_fsm_t st);
    return (st == PRESSED) || (st == RELEASE_PEND);
  endfunction

endpackage

// File: rtl/btn_evt_fifo.sv
// Show-ahead event FIFO: head is registered and holds its last value while empty.
module btn_evt_fifo
  import btn_evt_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  btn_evt_t push_data,
  output logic     full,
  input  logic     pop_ready,
  output logic     valid,
  output btn_evt_t head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  btn_evt_t      mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  btn_evt_t      head_q, head_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign valid   = (cnt_q != '0);
  assign head    = head_q;
  assign do_push = push && !full;
  assign do_pop  = valid && pop_ready;

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    head_d = head_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    // The next head is the entry being written right now when the queue is about to hold only it.
    if (cnt_d != '0) head_d = (do_push && (rd_d == wr_q)) ? push_data : mem_q[rd_d];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end

endmodule

// File: rtl/button_event_ctrl.sv
// Push-button debounce controller: per-button debounce/long-press FSMs sampled on the slow
// tick, one pending slot per button, lowest-index arbitration into a show-ahead event FIFO.
module button_event_ctrl
  import btn_evt_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int STABLE_TICKS = 3,
  parameter int HOLD_TICKS   = 100,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_en,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_state,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [1:0]       evt_type,
  output logic [2:0]       evt_idx,
  output logic             overflow
);

  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);

  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [N_BTN-1:0] slot_full, grant, drop;
  evt_type_t        slot_t [N_BTN];
  logic             ovf_q, ovf_d;
  logic             fifo_full, fifo_push;
  btn_evt_t         push_evt, head;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_fsm_t      st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          ld_q, ld_d, held_q, drop_c, s;
    evt_type_t     emit, slot_q, slot_d;

    assign s            = sync2_q[i];
    assign btn_state[i] = held_q;
    assign slot_full[i] = (slot_q != EVT_NONE);
    assign slot_t[i]    = slot_q;
    assign drop[i]      = drop_c;

    always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      hcnt_d = hcnt_q;
      ld_d   = ld_q;
      emit   = EVT_NONE;
      if (tick_en) begin
        case (st_q)
          RELEASED: begin
            if (s) begin
              if (STABLE_TICKS == 1) begin
                st_d   = PRESSED;
                emit   = PRESS;
                hcnt_d = '0;
                ld_d   = 1'b0;
              end else begin
                st_d  = PRESS_PEND;
                cnt_d = CW'(1);
              end
            end
          end
          PRESS_PEND: begin
            if (!s) begin
              st_d  = RELEASED;
              cnt_d = '0;
            end else if (cnt_q + CW'(1) == CW'(STABLE_TICKS)) begin
              st_d   = PRESSED;
              cnt_d  = '0;
              emit   = PRESS;
              hcnt_d = '0;
              ld_d   = 1'b0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          PRESSED: begin
            if (!s) begin
              if (STABLE_TICKS == 1) begin
                st_d = RELEASED;
                emit = RELEASE;
              end else begin
                st_d  = RELEASE_PEND;
                cnt_d = CW'(1);
              end
            end else if (!ld_q) begin
              hcnt_d = hcnt_q + HW'(1);
              if (hcnt_q + HW'(1) == HW'(HOLD_TICKS)) begin
                emit = LONG;
                ld_d = 1'b1;
              end
            end
          end
          RELEASE_PEND: begin
            // A bounce back to pressed keeps hcnt/long_done so a hold is never reported twice.
            if (s) begin
              st_d  = PRESSED;
              cnt_d = '0;
            end else if (cnt_q + CW'(1) == CW'(STABLE_TICKS)) begin
              st_d  = RELEASED;
              cnt_d = '0;
              emit  = RELEASE;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          default: st_d = RELEASED;
        endcase
      end

      slot_d = slot_q;
      drop_c = 1'b0;
      if (grant[i]) slot_d = EVT_NONE;
      if (emit != EVT_NONE) begin
        if ((slot_q == EVT_NONE) || grant[i]) slot_d = emit;
        else                                  drop_c = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        st_q   <= RELEASED;
        cnt_q  <= '0;
        hcnt_q <= '0;
        ld_q   <= 1'b0;
        held_q <= 1'b0;
        slot_q <= EVT_NONE;
      end else begin
        st_q   <= st_d;
        cnt_q  <= cnt_d;
        hcnt_q <= hcnt_d;
        ld_q   <= ld_d;
        held_q <= is_held(st_d);
        slot_q <= slot_d;
      end
    end
  end

  // Fixed priority: the lowest-index full slot wins whenever the FIFO has room at cycle start.
  always_comb begin
    grant     = '0;
    fifo_push = 1'b0;
    push_evt  = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (slot_full[i] && !fifo_push && !fifo_full) begin
        grant[i]     = 1'b1;
        fifo_push    = 1'b1;
        push_evt.t   = slot_t[i];
        push_evt.idx = 3'(i);
      end
    end
  end

  always_comb ovf_d = ovf_q | (|drop);

  always_ff @(posedge clk) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  btn_evt_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_data(push_evt),
    .full     (fifo_full),
    .pop_ready(evt_ready),
    .valid    (evt_valid),
    .head     (head)
  );

  assign evt_type = head.t;
  assign evt_idx  = head.idx;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl with STABLE_TICKS=3, HOLD_TICKS=5, FIFO_DEPTH=4 and a
// slow tick every 4th clock; button changes are applied just after a tick edge.
module tb_button_event_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_en;
  logic [3:0] btn_raw;
  logic [3:0] btn_state;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_type;
  logic [2:0] evt_idx;
  logic       overflow;

  int vectors     = 0;
  int miscompares = 0;
  int phase       = 0;

  localparam logic [1:0] T_PRESS = 2'd1, T_RELEASE = 2'd2, T_LONG = 2'd3;

  button_event_ctrl #(
    .N_BTN(4), .STABLE_TICKS(3), .HOLD_TICKS(5), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .tick_en(tick_en), .btn_raw(btn_raw),
    .btn_state(btn_state), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_type(evt_type), .evt_idx(evt_idx), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    tick_en = 1'b0;
    forever begin
      @(negedge clk);
      phase   = (phase + 1) % 4;
      tick_en = (phase == 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    int n = 0;
    @(posedge clk);
    while (!tick_en && n < 8) begin
      @(posedge clk);
      n++;
    end
    if (n >= 8) begin
      miscompares++;
      $display("FAIL tick_wait: observed no tick, required tick within 8 cycles");
    end
    #1;
  endtask

  task automatic expect_head(input string tag, input logic [1:0] t, input logic [2:0] idx);
    check({tag, "_valid"}, 8'(evt_valid), 8'd1);
    check({tag, "_type"},  8'(evt_type),  8'(t));
    check({tag, "_idx"},   8'(evt_idx),   8'(idx));
  endtask

  task automatic pop();
    evt_ready = 1'b1;
    cyc();
    evt_ready = 1'b0;
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    btn_raw   = 4'b0000;
    evt_ready = 1'b0;
    repeat (3) cyc();
    check("rst_btn_state", 8'(btn_state), 8'h0);
    check("rst_evt_valid", 8'(evt_valid), 8'h0);
    check("rst_evt_type",  8'(evt_type),  8'h0);
    check("rst_evt_idx",   8'(evt_idx),   8'h0);
    check("rst_overflow",  8'(overflow),  8'h0);
    reset = 1'b0;

    // Clean press and release of btn0.
    wait_tick();
    btn_raw = 4'b0001;
    wait_tick();
    wait_tick();
    check("p0_pend_state", 8'(btn_state), 8'h0);
    wait_tick();
    check("p0_commit_state", 8'(btn_state), 8'h1);
    check("p0_not_yet_valid", 8'(evt_valid), 8'h0);
    cyc();
    expect_head("p0_press", T_PRESS, 3'd0);
    pop();
    check("p0_popped", 8'(evt_valid), 8'h0);
    wait_tick();
    btn_raw = 4'b0000;
    wait_tick();
    wait_tick();
    check("r0_pend_state", 8'(btn_state), 8'h1);
    wait_tick();
    check("r0_commit_state", 8'(btn_state), 8'h0);
    cyc();
    expect_head("r0_release", T_RELEASE, 3'd0);
    pop();

    // Glitch on btn1 shorter than the debounce window.
    wait_tick();
    btn_raw = 4'b0010;
    wait_tick();
    wait_tick();
    btn_raw = 4'b0000;
    wait_tick();
    wait_tick();
    check("g1_state", 8'(btn_state), 8'h0);
    check("g1_no_evt", 8'(evt_valid), 8'h0);
    check("g1_overflow", 8'(overflow), 8'h0);

    // Long press on btn2 with a bounce during release.
    wait_tick();
    btn_raw = 4'b0100;
    repeat (3) wait_tick();
    check("l2_state", 8'(btn_state), 8'h4);
    cyc();
    expect_head("l2_press", T_PRESS, 3'd2);
    pop();
    repeat (4) wait_tick();
    check("l2_no_long_early", 8'(evt_valid), 8'h0);
    wait_tick();
    cyc();
    expect_head("l2_long", T_LONG, 3'd2);
    pop();
    repeat (3) wait_tick();
    check("l2_single_long", 8'(evt_valid), 8'h0);
    btn_raw = 4'b0000;
    wait_tick();
    btn_raw = 4'b0100;
    wait_tick();
    check("l2_bounce_state", 8'(btn_state), 8'h4);
    wait_tick();
    wait_tick();
    check("l2_bounce_no_evt", 8'(evt_valid), 8'h0);
    btn_raw = 4'b0000;
    repeat (3) wait_tick();
    cyc();
    expect_head("l2_release", T_RELEASE, 3'd2);
    pop();

    // All four buttons commit on the same tick.
    wait_tick();
    btn_raw = 4'b1111;
    repeat (3) wait_tick();
    check("all_state", 8'(btn_state), 8'hf);
    repeat (4) cyc();
    expect_head("all_0", T_PRESS, 3'd0);
    pop();
    expect_head("all_1", T_PRESS, 3'd1);
    pop();
    expect_head("all_2", T_PRESS, 3'd2);
    pop();
    expect_head("all_3", T_PRESS, 3'd3);
    pop();
    check("all_empty", 8'(evt_valid), 8'h0);

    // Held buttons produce four LONG events that fill the FIFO; later events stall in slots.
    repeat (3) wait_tick();
    repeat (4) cyc();
    expect_head("full_head", T_LONG, 3'd0);
    wait_tick();
    btn_raw = 4'b1100;
    repeat (3) wait_tick();
    check("stall_state", 8'(btn_state), 8'hc);
    check("stall_no_ovf", 8'(overflow), 8'h0);
    btn_raw = 4'b1101;
    repeat (3) wait_tick();
    check("ovf_set", 8'(overflow), 8'h1);
    check("ovf_state", 8'(btn_state), 8'hd);
    expect_head("drain_0", T_LONG, 3'd0);
    pop(); cyc();
    expect_head("drain_1", T_LONG, 3'd1);
    pop(); cyc();
    expect_head("drain_2", T_LONG, 3'd2);
    pop(); cyc();
    expect_head("drain_3", T_LONG, 3'd3);
    pop(); cyc();
    expect_head("drain_4", T_RELEASE, 3'd0);
    pop(); cyc();
    expect_head("drain_5", T_RELEASE, 3'd1);
    pop(); cyc();
    check("drain_empty", 8'(evt_valid), 8'h0);
    check("drain_ovf_sticky", 8'(overflow), 8'h1);

    // btn0 was re-pressed (its PRESS dropped) and eventually reports LONG; reset while queued.
    n = 0;
    while (!evt_valid && n < 40) begin
      cyc();
      n++;
    end
    expect_head("pre_rst_long", T_LONG, 3'd0);
    reset = 1'b1;
    cyc();
    check("mid_rst_valid", 8'(evt_valid), 8'h0);
    check("mid_rst_state", 8'(btn_state), 8'h0);
    check("mid_rst_ovf",   8'(overflow),  8'h0);
    check("mid_rst_type",  8'(evt_type),  8'h0);
    check("mid_rst_idx",   8'(evt_idx),   8'h0);
    wait_tick();
    check("rst_tick_ignored", 8'(btn_state), 8'h0);
    reset = 1'b0;
    wait_tick();
    wait_tick();
    check("redeb_pend", 8'(btn_state), 8'h0);
    wait_tick();
    check("redeb_state", 8'(btn_state), 8'hd);
    cyc();
    expect_head("redeb_0", T_PRESS, 3'd0);
    pop();
    expect_head("redeb_2", T_PRESS, 3'd2);
    pop();
    expect_head("redeb_3", T_PRESS, 3'd3);
    pop();
    check("redeb_empty", 8'(evt_valid), 8'h0);
    check("redeb_ovf", 8'(overflow), 8'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
